syn_array_mem: RTL and testbench

- Array-memory responder: the other end of the per-array port that generated kernels (`main`) drive as initiator, i.e. `<arr>WEnable_a`, `<arr>Addr_a`, `<arr>WData_a` out of the kernel and `<arr>RData_a` back in.
- Holds array contents and answers kernel accesses on port a with one-cycle read latency.
- Provides a second host port b so benches and the top level can preload and dump arrays.
- After reset it self-clears to `INIT_VAL` before accepting traffic.

---
 rtl/syn_arr_pkg.sv | 13 +
 rtl/syn_arr_port.sv | 52 +++++
 rtl/syn_array_mem.sv | 111 +++++++++++
 tb/tb_syn_array_mem.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/syn_arr_pkg.sv
// Shared types and constants for the array-memory responder.
package syn_arr_pkg;

  localparam int SYN_WORD_W = 64;

  typedef logic signed [SYN_WORD_W-1:0] word_t;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } arr_state_e;

endpackage

// File: rtl/syn_arr_port.sv
// One access port of the array memory: registered read data with an
// optional same-port write-first forward path.
// Optional feature macro: SYN_ARR_WRITE_FORWARD_EN (write-first when defined).
module syn_arr_port
  import syn_arr_pkg::*;
#(
  parameter int DATA_W = SYN_WORD_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     active,    // memory is in READY
  input  logic                     in_range,  // address below DEPTH
  input  logic                     wr_fwd,    // this port's write lands this cycle
  input  logic signed [DATA_W-1:0] mem_word,  // current (old) word at the address
  input  logic signed [DATA_W-1:0] wdata,
  output logic signed [DATA_W-1:0] rdata
);

  logic signed [DATA_W-1:0] rdata_q;
  logic signed [DATA_W-1:0] rdata_d;

`ifndef SYN_ARR_WRITE_FORWARD_EN
  // Forward inputs only matter in the write-first build.
  logic unused_fwd;
  assign unused_fwd = ^{wr_fwd, wdata};
`endif

  // Next read word: zero while clearing or out of range, else the addressed word.
  always_comb begin
    rdata_d = '0;
    if (active && in_range) begin
      rdata_d = mem_word;
`ifdef SYN_ARR_WRITE_FORWARD_EN
      if (wr_fwd) begin
        rdata_d = wdata;
      end
`endif
    end
  end

  // Read data register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/syn_array_mem.sv
// Array-memory responder: kernel port a, host port b, self-clear after reset.
// Optional feature macro: SYN_ARR_WRITE_FORWARD_EN (same-port write-first reads).
module syn_array_mem
  import syn_arr_pkg::*;
#(
  parameter int                       DATA_W   = SYN_WORD_W,
  parameter int                       ADDR_W   = 1,
  parameter int                       DEPTH    = 2 ** ADDR_W,
  parameter logic signed [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wEnable_a,
  input  logic [ADDR_W-1:0]        addr_a,
  input  logic signed [DATA_W-1:0] wData_a,
  output logic signed [DATA_W-1:0] rData_a,
  input  logic                     wEnable_b,
  input  logic [ADDR_W-1:0]        addr_b,
  input  logic signed [DATA_W-1:0] wData_b,
  output logic signed [DATA_W-1:0] rData_b,
  output logic                     ready
);

  // Counter is one bit wider than the address so DEPTH = 2**ADDR_W cannot wrap.
  localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);

  logic signed [DATA_W-1:0] mem [DEPTH];

  arr_state_e      state_q, state_d;
  logic [ADDR_W:0] cnt_q, cnt_d;

  logic                     is_ready;
  logic                     in_range_a, in_range_b;
  logic                     wr_a, wr_b;
  logic signed [DATA_W-1:0] word_a, word_b;

  assign is_ready   = (state_q == READY);
  assign in_range_a = ({1'b0, addr_a} < DEPTH_L);
  assign in_range_b = ({1'b0, addr_b} < DEPTH_L);

  // Effective writes: port a always wins a same-address collision.
  assign wr_a = is_ready && wEnable_a && in_range_a;
  assign wr_b = is_ready && wEnable_b && in_range_b && !(wr_a && (addr_a == addr_b));

  // Old contents seen by each port; out-of-range addresses read as zero.
  assign word_a = in_range_a ? mem[addr_a] : '0;
  assign word_b = in_range_b ? mem[addr_b] : '0;

  // Clear sequencing: walk every word once, then stay READY until reset.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST_IDX) begin
        state_d = READY;
      end
    end
  end

  // FSM and clear-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Array writes: clear pattern first, then arbitrated port writes (a last so it wins).
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      mem[cnt_q[ADDR_W-1:0]] <= INIT_VAL;
    end else begin
      if (wr_b) begin
        mem[addr_b] <= wData_b;
      end
      if (wr_a) begin
        mem[addr_a] <= wData_a;
      end
    end
  end

  syn_arr_port #(.DATA_W(DATA_W)) u_port_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .active   (is_ready),
    .in_range (in_range_a),
    .wr_fwd   (wr_a),
    .mem_word (word_a),
    .wdata    (wData_a),
    .rdata    (rData_a)
  );

  syn_arr_port #(.DATA_W(DATA_W)) u_port_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .active   (is_ready),
    .in_range (in_range_b),
    .wr_fwd   (wr_b),
    .mem_word (word_b),
    .wdata    (wData_b),
    .rdata    (rData_b)
  );

  assign ready = is_ready;

endmodule

// File: tb/tb_syn_array_mem.sv
// Directed + random bench for syn_array_mem (ADDR_W=4, DEPTH=10, INIT_VAL=5).
// Expected read behaviour follows SYN_ARR_WRITE_FORWARD_EN when defined.
module tb_syn_array_mem;

  localparam int          AW    = 4;
  localparam int          DEP   = 10;
  localparam logic [63:0] INITV = 64'd5;

  logic               clk;
  logic               rst_n;
  logic               wEnable_a, wEnable_b;
  logic [AW-1:0]      addr_a, addr_b;
  logic signed [63:0] wData_a, wData_b;
  logic signed [63:0] rData_a, rData_b;
  logic               ready;

  int checks = 0;
  int errors = 0;

  // Reference contents of the array as the host would see it.
  logic [63:0] model_mem [DEP];

  syn_array_mem #(
    .DATA_W   (64),
    .ADDR_W   (AW),
    .DEPTH    (DEP),
    .INIT_VAL (64'sd5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wEnable_a (wEnable_a),
    .addr_a    (addr_a),
    .wData_a   (wData_a),
    .rData_a   (rData_a),
    .wEnable_b (wEnable_b),
    .addr_b    (addr_b),
    .wData_b   (wData_b),
    .rData_b   (rData_b),
    .ready     (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEP; i++) model_mem[i] = INITV;
  endtask

  task automatic idle();
    wEnable_a = 1'b0; addr_a = '0; wData_a = '0;
    wEnable_b = 1'b0; addr_b = '0; wData_b = '0;
  endtask

  // Wait (bounded) for ready; optionally hammer both ports while clearing.
  task automatic wait_ready(input bit poke);
    int n = 0;
    while (!ready && n < 100) begin
      if (poke) begin
        wEnable_a = 1'b1; addr_a = 4'd3; wData_a = 64'd77;
        wEnable_b = 1'b1; addr_b = 4'd4; wData_b = 64'd88;
      end
      @(posedge clk); #1;
      n++;
      chk("clear_rdata_a", rData_a, 64'd0);
      chk("clear_rdata_b", rData_b, 64'd0);
    end
    idle();
    chk("ready_latency", 64'(n), 64'(DEP));
    $display("clear: ready after %0d cycles", n);
  endtask

  // One clock of traffic on both ports, checked against the model.
  task automatic cycle(input string tag,
                       input bit wa, input logic [AW-1:0] aa, input logic [63:0] da,
                       input bit wb, input logic [AW-1:0] ab, input logic [63:0] db);
    bit          in_a, in_b, eff_a, eff_b;
    logic [63:0] exp_a, exp_b;
    in_a  = (int'(aa) < DEP);
    in_b  = (int'(ab) < DEP);
    eff_a = wa && in_a;
    eff_b = wb && in_b && !(eff_a && aa == ab);
    exp_a = in_a ? model_mem[aa] : 64'd0;
    exp_b = in_b ? model_mem[ab] : 64'd0;
`ifdef SYN_ARR_WRITE_FORWARD_EN
    if (eff_a) exp_a = da;
    if (eff_b) exp_b = db;
`endif
    wEnable_a = wa; addr_a = aa; wData_a = da;
    wEnable_b = wb; addr_b = ab; wData_b = db;
    @(posedge clk); #1;
    chk({tag, "_a"}, rData_a, exp_a);
    chk({tag, "_b"}, rData_b, exp_b);
    chk({tag, "_ready"}, {63'd0, ready}, 64'd1);
    if (eff_b) model_mem[ab] = db;
    if (eff_a) model_mem[aa] = da;
    $display("%s: wa=%0d a=%0d da=%0h ra=%0h | wb=%0d b=%0d db=%0h rb=%0h",
             tag, wa, aa, da, rData_a, wb, ab, db, rData_b);
    idle();
  endtask

  initial begin
    idle();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rdata_a", rData_a, 64'd0);
    chk("reset_rdata_b", rData_b, 64'd0);
    chk("reset_ready", {63'd0, ready}, 64'd0);

    // Reset clear: ready after exactly DEPTH cycles, early writes ignored.
    rst_n = 1'b1;
    model_clear();
    wait_ready(1'b1);
    for (int i = 0; i < 16; i++) cycle("host_rd", 0, 4'(i), 0, 0, 4'(i), 0);

    // Kernel latency.
    cycle("k_wr", 1, 4'd1, 64'hffff_ffff_ffff_fff9, 0, 0, 0);
    cycle("k_rd", 0, 4'd1, 0, 0, 4'd1, 0);
    chk("k_rd_neg7", rData_a, 64'hffff_ffff_ffff_fff9);

    // Read-during-write on port a.
    cycle("rdw_pre", 0, 0, 0, 1, 4'd0, 64'd3);
    cycle("rdw", 1, 4'd0, 64'd21, 0, 4'd5, 0);
    cycle("rdw_post", 0, 4'd0, 0, 0, 4'd0, 0);
    chk("rdw_mem0", rData_b, 64'd21);

    // Write collision on address 2, b reads old value that cycle.
    cycle("coll_pre", 0, 0, 0, 1, 4'd2, 64'd40);
    cycle("coll", 1, 4'd2, 64'd10, 1, 4'd2, 64'd20);
    cycle("coll_post", 0, 4'd2, 0, 0, 4'd2, 0);
    chk("coll_win", rData_b, 64'd10);

    // Out of range.
    cycle("oor_wr", 1, 4'd12, 64'd55, 1, 4'd15, 64'd66);
    cycle("oor_rd", 0, 4'd12, 0, 0, 4'd15, 0);
    for (int i = 0; i < DEP; i++) cycle("inrange_rd", 0, 4'(i), 0, 0, 4'(DEP - 1 - i), 0);

    // Random traffic with forced collisions now and then.
    for (int t = 0; t < 200; t++) begin
      logic [AW-1:0] ra, rb;
      ra = 4'($urandom_range(0, 15));
      rb = ($urandom_range(0, 3) == 0) ? ra : 4'($urandom_range(0, 15));
      cycle("rand", 1'($urandom), ra, {$urandom, $urandom},
                    1'($urandom), rb, {$urandom, $urandom});
    end

    // Mid-operation reset.
    cycle("mid_wr", 1, 4'd3, 64'd99, 0, 0, 0);
    cycle("mid_rd", 0, 4'd3, 0, 0, 4'd3, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_rdata_a", rData_a, 64'd0);
    chk("mid_rst_rdata_b", rData_b, 64'd0);
    chk("mid_rst_ready", {63'd0, ready}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_clear();
    wait_ready(1'b0);
    cycle("reclear_rd", 0, 4'd3, 0, 0, 4'd3, 0);
    chk("reclear_init", rData_a, INITV);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
